// File: rtl/uart_pkg.sv
// Shared definitions for the UART transceiver: parity modes, FSM encodings
// and the parity helper used by both the transmitter and the receiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP
  } rx_state_t;

  // Odd parity is the inverse of the data XOR; even parity is the XOR itself.
  function automatic logic parity_bit(input logic xor_val, input int mode);
    return (mode == PAR_ODD) ? ~xor_val : xor_val;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: counts 0..DIV-1 and emits a registered
// one-cycle tick on the wrap, so the first tick lands DIV cycles after reset.
module uart_baud_gen #(
  parameter int SIZ = 8,
  parameter int DIV = 163
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_tick
);

  logic [SIZ-1:0] r_count;
  logic           r_tick;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (r_count == SIZ'(DIV - 1)) begin
      r_count <= '0;
      r_tick  <= 1'b1;
    end else begin
      r_count <= r_count + SIZ'(1);
      r_tick  <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART with 16x oversampling, optional parity and configurable
// stop length; TX and RX FSMs share one baud tick generator.
//
// state    | meaning
// IDLE     | TX: line high, waiting for start / RX: waiting for a low line
// START    | start bit (RX checks mid-bit at tick 7 to reject glitches)
// DATA     | DBIT data bits, LSB first, 16 ticks each
// PAR      | parity bit (skipped when PARITY = PAR_NONE)
// STOP     | stop bit, SB_TICK ticks; done pulse on exit
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DIV     = 163,
  parameter int SIZ     = 8,
  parameter int PARITY  = 0
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_tx_start,
  input  logic [DBIT-1:0] i_tx_data,
  output logic            o_tx,
  output logic            o_tx_busy,
  output logic            o_tx_done_tick,
  input  logic            i_rx,
  output logic [DBIT-1:0] o_rx_data,
  output logic            o_rx_done_tick,
  output logic            o_parity_err,
  output logic            o_frame_err
);

  localparam logic [5:0] TICK_MID  = 6'd7;
  localparam logic [5:0] TICK_END  = 6'd15;
  localparam logic [5:0] TICK_STOP = 6'(SB_TICK - 1);
  localparam logic [3:0] LAST_BIT  = 4'(DBIT - 1);

  logic w_tick;

  uart_baud_gen #(.SIZ(SIZ), .DIV(DIV)) u_baud_gen (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .o_tick  (w_tick)
  );

  tx_state_t       r_tx_state, w_tx_state_nx;
  logic [5:0]      r_tx_n, w_tx_n_nx;
  logic [3:0]      r_tx_b, w_tx_b_nx;
  logic [DBIT-1:0] r_tx_shift, w_tx_shift_nx;
  logic            r_tx_par, w_tx_par_nx;
  logic            r_tx, w_tx_nx;
  logic            r_tx_done, w_tx_done_nx;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_n     <= '0;
      r_tx_b     <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_n     <= w_tx_n_nx;
      r_tx_b     <= w_tx_b_nx;
      r_tx_shift <= w_tx_shift_nx;
      r_tx_par   <= w_tx_par_nx;
      r_tx       <= w_tx_nx;
      r_tx_done  <= w_tx_done_nx;
    end
  end

  // Line level is computed one step ahead so o_tx comes straight from a flop.
  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_n_nx     = r_tx_n;
    w_tx_b_nx     = r_tx_b;
    w_tx_shift_nx = r_tx_shift;
    w_tx_par_nx   = r_tx_par;
    w_tx_nx       = r_tx;
    w_tx_done_nx  = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_nx = 1'b1;
        if (i_tx_start) begin
          w_tx_state_nx = TX_START;
          w_tx_n_nx     = '0;
          w_tx_shift_nx = i_tx_data;
          w_tx_par_nx   = parity_bit(^i_tx_data, PARITY);
          w_tx_nx       = 1'b0;
        end
      end
      TX_START: begin
        if (w_tick) begin
          if (r_tx_n == TICK_END) begin
            w_tx_state_nx = TX_DATA;
            w_tx_n_nx     = '0;
            w_tx_b_nx     = '0;
            w_tx_nx       = r_tx_shift[0];
          end else begin
            w_tx_n_nx = r_tx_n + 6'd1;
          end
        end
      end
      TX_DATA: begin
        if (w_tick) begin
          if (r_tx_n == TICK_END) begin
            w_tx_n_nx     = '0;
            w_tx_shift_nx = {1'b0, r_tx_shift[DBIT-1:1]};
            if (r_tx_b == LAST_BIT) begin
              if (PARITY != PAR_NONE) begin
                w_tx_state_nx = TX_PAR;
                w_tx_nx       = r_tx_par;
              end else begin
                w_tx_state_nx = TX_STOP;
                w_tx_nx       = 1'b1;
              end
            end else begin
              w_tx_b_nx = r_tx_b + 4'd1;
              w_tx_nx   = r_tx_shift[1];
            end
          end else begin
            w_tx_n_nx = r_tx_n + 6'd1;
          end
        end
      end
      TX_PAR: begin
        if (w_tick) begin
          if (r_tx_n == TICK_END) begin
            w_tx_state_nx = TX_STOP;
            w_tx_n_nx     = '0;
            w_tx_nx       = 1'b1;
          end else begin
            w_tx_n_nx = r_tx_n + 6'd1;
          end
        end
      end
      TX_STOP: begin
        if (w_tick) begin
          if (r_tx_n == TICK_STOP) begin
            w_tx_state_nx = TX_IDLE;
            w_tx_done_nx  = 1'b1;
            w_tx_nx       = 1'b1;
          end else begin
            w_tx_n_nx = r_tx_n + 6'd1;
          end
        end
      end
      default: w_tx_state_nx = TX_IDLE;
    endcase
  end

  assign o_tx           = r_tx;
  assign o_tx_busy      = (r_tx_state != TX_IDLE);
  assign o_tx_done_tick = r_tx_done;

  logic            r_rx_sync1, r_rx_sync2;
  rx_state_t       r_rx_state, w_rx_state_nx;
  logic [5:0]      r_rx_n, w_rx_n_nx;
  logic [3:0]      r_rx_b, w_rx_b_nx;
  logic [DBIT-1:0] r_rx_shift, w_rx_shift_nx;
  logic            r_rx_par, w_rx_par_nx;
  logic [DBIT-1:0] r_rx_data, w_rx_data_nx;
  logic            r_perr, w_perr_nx;
  logic            r_ferr, w_ferr_nx;
  logic            r_rx_done, w_rx_done_nx;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_n     <= '0;
      r_rx_b     <= '0;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
      r_rx_data  <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_rx_done  <= 1'b0;
    end else begin
      r_rx_sync1 <= i_rx;
      r_rx_sync2 <= r_rx_sync1;
      r_rx_state <= w_rx_state_nx;
      r_rx_n     <= w_rx_n_nx;
      r_rx_b     <= w_rx_b_nx;
      r_rx_shift <= w_rx_shift_nx;
      r_rx_par   <= w_rx_par_nx;
      r_rx_data  <= w_rx_data_nx;
      r_perr     <= w_perr_nx;
      r_ferr     <= w_ferr_nx;
      r_rx_done  <= w_rx_done_nx;
    end
  end

  // Sampling counts restart at mid start bit, so tick 15 lands mid-bit after.
  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_n_nx     = r_rx_n;
    w_rx_b_nx     = r_rx_b;
    w_rx_shift_nx = r_rx_shift;
    w_rx_par_nx   = r_rx_par;
    w_rx_data_nx  = r_rx_data;
    w_perr_nx     = r_perr;
    w_ferr_nx     = r_ferr;
    w_rx_done_nx  = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (!r_rx_sync2) begin
          w_rx_state_nx = RX_START;
          w_rx_n_nx     = '0;
        end
      end
      RX_START: begin
        if (w_tick) begin
          if (r_rx_n == TICK_MID) begin
            w_rx_n_nx     = '0;
            w_rx_b_nx     = '0;
            w_rx_state_nx = r_rx_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            w_rx_n_nx = r_rx_n + 6'd1;
          end
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          if (r_rx_n == TICK_END) begin
            w_rx_n_nx     = '0;
            w_rx_shift_nx = {r_rx_sync2, r_rx_shift[DBIT-1:1]};
            if (r_rx_b == LAST_BIT) begin
              w_rx_state_nx = (PARITY != PAR_NONE) ? RX_PAR : RX_STOP;
            end else begin
              w_rx_b_nx = r_rx_b + 4'd1;
            end
          end else begin
            w_rx_n_nx = r_rx_n + 6'd1;
          end
        end
      end
      RX_PAR: begin
        if (w_tick) begin
          if (r_rx_n == TICK_END) begin
            w_rx_n_nx     = '0;
            w_rx_par_nx   = r_rx_sync2;
            w_rx_state_nx = RX_STOP;
          end else begin
            w_rx_n_nx = r_rx_n + 6'd1;
          end
        end
      end
      RX_STOP: begin
        if (w_tick) begin
          if (r_rx_n == TICK_STOP) begin
            w_rx_state_nx = RX_IDLE;
            w_rx_done_nx  = 1'b1;
            w_rx_data_nx  = r_rx_shift;
            w_ferr_nx     = ~r_rx_sync2;
            w_perr_nx     = (PARITY != PAR_NONE) &&
                            (r_rx_par != parity_bit(^r_rx_shift, PARITY));
          end else begin
            w_rx_n_nx = r_rx_n + 6'd1;
          end
        end
      end
      default: w_rx_state_nx = RX_IDLE;
    endcase
  end

  assign o_rx_data      = r_rx_data;
  assign o_rx_done_tick = r_rx_done;
  assign o_parity_err   = r_perr;
  assign o_frame_err    = r_ferr;

endmodule
